// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive framer.
// Optional feature macro: UART_RX_PARITY_EN (enables the parity bit and PAR_ERR).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_t;

  // Level of the serial line when no character is being sent.
  localparam logic IDLE_LEVEL = 1'b1;

  // Expected parity bit for a character: XOR of all data bits, inverted for odd parity.
  // Narrower characters are passed zero-extended, which does not change the XOR.
  function automatic logic parity_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_hold.sv
// Output holding register for received characters: valid/ready handshake
// plus detection of a new character arriving while the old one is unread.
module uart_rx_hold
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK_x16,
  input  logic                 RST_N,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 RX_READY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 overrun_set
);

  logic accept_s;
  logic load_ok_s;

  // Decide whether a completed character may enter the register or must be dropped.
  always_comb begin
    accept_s    = RX_VALID & RX_READY;
    load_ok_s   = load & (~RX_VALID | RX_READY);
    overrun_set = load & RX_VALID & ~RX_READY;
  end

  // Holding register: a load wins over a simultaneous read so no character is lost.
  always_ff @(posedge CLK_x16) begin
    if (!RST_N) begin
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
    end else if (load_ok_s) begin
      RX_DATA  <= data;
      RX_VALID <= 1'b1;
    end else if (accept_s) begin
      RX_DATA  <= RX_DATA;
      RX_VALID <= 1'b0;
    end else begin
      RX_DATA  <= RX_DATA;
      RX_VALID <= RX_VALID;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: samples RXD on rising edges of the CDR mid-bit level,
// assembles start/data/[parity]/stop, and hands characters to uart_rx_hold.
// Optional feature macro: UART_RX_PARITY_EN (parity bit after the data, PAR_ERR output).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 CLK_x16,
  input  logic                 RST_N,
  input  logic                 CLK_MID,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
`ifdef UART_RX_PARITY_EN
  output logic                 PAR_ERR,
`endif
  input  logic                 ERR_CLR
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_t              state_r;
  rx_state_t              state_nxt_s;
  logic                   clk_mid_d_r;
  logic                   rxd_d_r;
  logic                   mid_stb_s;
  logic [DATA_BITS-1:0]   shift_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic                   stop_cnt_r;
  logic                   load_s;
  logic                   frame_err_set_s;
  logic                   overrun_set_s;
`ifdef UART_RX_PARITY_EN
  logic                   par_err_set_s;
`endif

  // One-cycle strobe on each rising edge of the mid-bit level.
  always_comb begin
    mid_stb_s = CLK_MID & ~clk_mid_d_r;
  end

  // Next-state and per-state event decode.
  always_comb begin
    state_nxt_s     = state_r;
    load_s          = 1'b0;
    frame_err_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_set_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if ((rxd_d_r == IDLE_LEVEL) && (RXD != IDLE_LEVEL)) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (mid_stb_s) begin
          if (RXD == 1'b0) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;  // glitch on the line, not a real start bit
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (mid_stb_s && (bit_cnt_r == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt_s = PARITY;
`else
          state_nxt_s = STOP;
`endif
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (mid_stb_s) begin
          par_err_set_s = (parity_calc(8'(shift_r), ODD_PARITY) != RXD);
          state_nxt_s   = STOP;
        end else begin
          state_nxt_s   = PARITY;
        end
`else
        state_nxt_s = IDLE;
`endif
      end
      STOP: begin
        if (mid_stb_s) begin
          frame_err_set_s = (RXD == 1'b0);
          if (stop_cnt_r == LAST_STOP) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = STOP;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      DONE: begin
        load_s      = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register, input history and the data/bit/stop counters.
  always_ff @(posedge CLK_x16) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      clk_mid_d_r <= 1'b0;
      rxd_d_r     <= IDLE_LEVEL;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      stop_cnt_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      clk_mid_d_r <= CLK_MID;
      rxd_d_r     <= RXD;
      case (state_r)
        START: begin
          bit_cnt_r  <= '0;
          stop_cnt_r <= 1'b0;
        end
        DATA: begin
          if (mid_stb_s) begin
            shift_r   <= {RXD, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end else begin
            shift_r   <= shift_r;
          end
        end
        STOP: begin
          if (mid_stb_s) begin
            stop_cnt_r <= stop_cnt_r + 1'b1;
          end else begin
            stop_cnt_r <= stop_cnt_r;
          end
        end
        default: begin
          shift_r <= shift_r;
        end
      endcase
    end
  end

  // Sticky error flags; a new error event takes priority over a clear.
  always_ff @(posedge CLK_x16) begin
    if (!RST_N) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PAR_ERR   <= 1'b0;
`endif
    end else begin
      FRAME_ERR <= frame_err_set_s | (FRAME_ERR & ~ERR_CLR);
      OVERRUN   <= overrun_set_s   | (OVERRUN   & ~ERR_CLR);
`ifdef UART_RX_PARITY_EN
      PAR_ERR   <= par_err_set_s   | (PAR_ERR   & ~ERR_CLR);
`endif
    end
  end

  uart_rx_hold #(
    .DATA_BITS (DATA_BITS)
  ) u_hold (
    .CLK_x16     (CLK_x16),
    .RST_N       (RST_N),
    .load        (load_s),
    .data        (shift_r),
    .RX_READY    (RX_READY),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .overrun_set (overrun_set_s)
  );

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: stimulus pushes expected characters,
// a monitor pops and compares on every valid/ready handshake.
module tb_uart_rx_frame;

  localparam int STOP_BITS = 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       CLK_x16  = 1'b0;
  logic       RST_N    = 1'b0;
  logic       CLK_MID  = 1'b0;
  logic       RXD      = 1'b1;
  logic       RX_READY = 1'b1;
  logic       ERR_CLR  = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       FRAME_ERR;
  logic       OVERRUN;
`ifdef UART_RX_PARITY_EN
  logic       PAR_ERR;
`endif

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  uart_rx_frame #(
    .DATA_BITS  (8),
    .STOP_BITS  (STOP_BITS),
    .ODD_PARITY (1'b0)
  ) dut (
    .CLK_x16   (CLK_x16),
    .RST_N     (RST_N),
    .CLK_MID   (CLK_MID),
    .RXD       (RXD),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
`ifdef UART_RX_PARITY_EN
    .PAR_ERR   (PAR_ERR),
`endif
    .ERR_CLR   (ERR_CLR)
  );

  always #5 CLK_x16 = ~CLK_x16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance n clock edges, then step just past the edge to drive inputs.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_x16);
    #1;
  endtask

  // One bit period: 8 cycles with CLK_MID low, then it rises (bit centre) for 8 cycles.
  task automatic send_bit(input logic b);
    RXD = b; CLK_MID = 1'b0; cyc(8);
    CLK_MID = 1'b1; cyc(8);
  endtask

  // Whole frame up to the rising CLK_MID of the last stop bit.
  task automatic send_head(input logic [7:0] d, input logic stop_val, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_ON) send_bit((^d) ^ par_flip);
    for (int s = 0; s < STOP_BITS - 1; s++) send_bit(stop_val);
    RXD = stop_val; CLK_MID = 1'b0; cyc(8);
    CLK_MID = 1'b1;
  endtask

  task automatic tail();
    cyc(8);
    CLK_MID = 1'b0; RXD = 1'b1;
    cyc(16);
  endtask

  task automatic pulse_clr();
    ERR_CLR = 1'b1; cyc(1);
    ERR_CLR = 1'b0;
  endtask

  // Scoreboard monitor: every accepted character must match the oldest expected one.
  always @(negedge CLK_x16) begin
    if (RST_N && RX_VALID && RX_READY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL monitor_unexpected: got %0h expected none", RX_DATA);
      end else begin
        chk("monitor_data", {24'd0, RX_DATA}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    RST_N = 1'b0;
    cyc(3);
    @(negedge CLK_x16);
    chk("rst_data", {24'd0, RX_DATA}, 32'd0);
    chk("rst_valid", {31'd0, RX_VALID}, 32'd0);
    chk("rst_ferr", {31'd0, FRAME_ERR}, 32'd0);
    chk("rst_ovr", {31'd0, OVERRUN}, 32'd0);
    @(posedge CLK_x16); #1;
    RST_N = 1'b1;
    cyc(4);

    // 0xA5 clean frame, with latency and single-cycle pulse checks
    exp_q.push_back(8'hA5);
    send_head(8'hA5, 1'b1, 1'b0);
    @(negedge CLK_x16);
    @(negedge CLK_x16);
    chk("lat_valid_lo", {31'd0, RX_VALID}, 32'd0);
    @(negedge CLK_x16);
    chk("lat_valid_hi", {31'd0, RX_VALID}, 32'd1);
    chk("a5_data", {24'd0, RX_DATA}, 32'hA5);
    @(negedge CLK_x16);
    chk("a5_pulse_end", {31'd0, RX_VALID}, 32'd0);
    tail();
    chk("a5_ferr", {31'd0, FRAME_ERR}, 32'd0);

    // 0x3C with low stop bit
    exp_q.push_back(8'h3C);
    send_head(8'h3C, 1'b0, 1'b0);
    tail();
    chk("3c_ferr_set", {31'd0, FRAME_ERR}, 32'd1);
    cyc(5);
    chk("3c_ferr_sticky", {31'd0, FRAME_ERR}, 32'd1);
    pulse_clr();
    @(negedge CLK_x16);
    chk("3c_ferr_clr", {31'd0, FRAME_ERR}, 32'd0);
    cyc(2);

    // Overrun: 0x11 held, 0x22 discarded
    RX_READY = 1'b0;
    exp_q.push_back(8'h11);
    send_head(8'h11, 1'b1, 1'b0);
    tail();
    chk("ovr_first_valid", {31'd0, RX_VALID}, 32'd1);
    chk("ovr_first_flag", {31'd0, OVERRUN}, 32'd0);
    send_head(8'h22, 1'b1, 1'b0);
    tail();
    chk("ovr_data_kept", {24'd0, RX_DATA}, 32'h11);
    chk("ovr_valid", {31'd0, RX_VALID}, 32'd1);
    chk("ovr_flag", {31'd0, OVERRUN}, 32'd1);
    RX_READY = 1'b1;
    @(negedge CLK_x16);
    @(negedge CLK_x16);
    chk("ovr_valid_drop", {31'd0, RX_VALID}, 32'd0);
    cyc(1);
    pulse_clr();
    @(negedge CLK_x16);
    chk("ovr_clr", {31'd0, OVERRUN}, 32'd0);
    cyc(2);

    // Start glitch: line low 4 cycles, high again before the bit centre
    RXD = 1'b0; cyc(4);
    RXD = 1'b1; cyc(4);
    for (int k = 0; k < 12; k++) begin
      CLK_MID = 1'b1; cyc(8);
      CLK_MID = 1'b0; cyc(8);
    end
    chk("glitch_valid", {31'd0, RX_VALID}, 32'd0);
    chk("glitch_ferr", {31'd0, FRAME_ERR}, 32'd0);
    chk("glitch_ovr", {31'd0, OVERRUN}, 32'd0);

    // Reset during data bit 3 of 0xFF, then a clean 0x5A
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    RXD = 1'b1; CLK_MID = 1'b0; cyc(4);
    RST_N = 1'b0;
    cyc(2);
    @(negedge CLK_x16);
    chk("mrst_data", {24'd0, RX_DATA}, 32'd0);
    chk("mrst_valid", {31'd0, RX_VALID}, 32'd0);
    chk("mrst_ferr", {31'd0, FRAME_ERR}, 32'd0);
    chk("mrst_ovr", {31'd0, OVERRUN}, 32'd0);
    @(posedge CLK_x16); #1;
    RST_N = 1'b1;
    for (int k = 0; k < 8; k++) begin
      CLK_MID = 1'b0; cyc(8);
      CLK_MID = 1'b1; cyc(8);
    end
    CLK_MID = 1'b0; cyc(4);
    chk("mrst_abandon", {31'd0, RX_VALID}, 32'd0);
    exp_q.push_back(8'h5A);
    send_head(8'h5A, 1'b1, 1'b0);
    tail();
    chk("5a_ferr", {31'd0, FRAME_ERR}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    exp_q.push_back(8'h07);
    send_head(8'h07, 1'b1, 1'b0);
    tail();
    chk("par_ok", {31'd0, PAR_ERR}, 32'd0);
    exp_q.push_back(8'h07);
    send_head(8'h07, 1'b1, 1'b1);
    tail();
    chk("par_bad", {31'd0, PAR_ERR}, 32'd1);
    chk("par_bad_data", {24'd0, RX_DATA}, 32'h07);
    pulse_clr();
    @(negedge CLK_x16);
    chk("par_clr", {31'd0, PAR_ERR}, 32'd0);
`endif

    cyc(4);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
